audio_note_sequencer: RTL and testbench

AUDIO_NOTE_SEQUENCER -- requirements
Module: audio_note_sequencer

---
 rtl/audio_note_sequencer.sv | 158 +++++++++++++++
 tb/tb_audio_note_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_note_sequencer.sv
// audio_note_sequencer: steps through a small note pattern at a programmable
// tempo, presenting one note code per step to a tone generator.
// Optional feature macro: SEQ_GAP_EN -- adds a GAP state that silences the
// gate for the final cycle of every step (articulation between notes).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not playing; all outputs held at 0
// PLAY  | sounding the current step; step timer counting down to 0
// GAP   | last cycle of a step with gate forced low (SEQ_GAP_EN only)

module audio_note_sequencer #(
  parameter  int STEPS   = 8,
  parameter  int TEMPO_W = 16,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               start,
  input  logic               stop,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [7:0]         wr_data,
  output logic [6:0]         note_out,
  output logic               gate,
  output logic [AW-1:0]      step_idx,
  output logic               step_strobe,
  output logic               busy
);

`ifdef SEQ_GAP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1} state_t;
`endif

  state_t               state_q, state_d;
  logic [TEMPO_W-1:0]   cnt_q, cnt_d;
  logic [TEMPO_W-1:0]   tempo_eff;
  logic [AW-1:0]        idx_d;
  logic [AW-1:0]        ent_idx;
  logic [6:0]           note_d;
  logic                 gate_d;
  logic                 strobe_d;
  logic                 busy_d;
  logic                 do_entry;
  logic [7:0]           pattern [STEPS];

  // A tempo of 0 would give a 1-cycle step; clamp so every step is >= 2 cycles.
  assign tempo_eff = (tempo == '0) ? TEMPO_W'(1) : tempo;

  // Pattern storage: writes are accepted in any state, even with ena low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STEPS; i++) begin
        pattern[i] <= '0;
      end
    end else if (wr_en) begin
      pattern[wr_addr] <= wr_data;
    end
  end

  // State, step timer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      step_idx    <= '0;
      note_out    <= '0;
      gate        <= 1'b0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_idx    <= idx_d;
      note_out    <= note_d;
      gate        <= gate_d;
      step_strobe <= strobe_d;
      busy        <= busy_d;
    end
  end

  // Next-state and output decode. Everything holds while ena is low; stop
  // has priority over start. A step entry reads the pattern before any
  // same-edge write lands, so such a write shows up on the next visit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = step_idx;
    note_d   = note_out;
    gate_d   = gate;
    strobe_d = step_strobe;
    busy_d   = busy;
    do_entry = 1'b0;
    ent_idx  = step_idx + AW'(1);

    if (ena) begin
      strobe_d = 1'b0;
      if (stop) begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        note_d  = '0;
        gate_d  = 1'b0;
        busy_d  = 1'b0;
      end else if (start) begin
        do_entry = 1'b1;
        ent_idx  = '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_d = S_IDLE;
          end
          S_PLAY: begin
            if (cnt_q == '0) begin
              do_entry = 1'b1;
`ifdef SEQ_GAP_EN
            end else if (cnt_q == TEMPO_W'(1)) begin
              state_d = S_GAP;
              cnt_d   = '0;
              gate_d  = 1'b0;
`endif
            end else begin
              cnt_d = cnt_q - TEMPO_W'(1);
            end
          end
`ifdef SEQ_GAP_EN
          S_GAP: begin
            do_entry = 1'b1;
          end
`endif
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            note_d  = '0;
            gate_d  = 1'b0;
            busy_d  = 1'b0;
          end
        endcase
      end

      if (do_entry) begin
        state_d  = S_PLAY;
        cnt_d    = tempo_eff;
        idx_d    = ent_idx;
        note_d   = pattern[ent_idx][6:0];
        gate_d   = ~pattern[ent_idx][7];
        strobe_d = 1'b1;
        busy_d   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Directed bench for audio_note_sequencer: a control-vector table plus
// hand-written multi-cycle sequences. Builds with or without SEQ_GAP_EN.

module tb_audio_note_sequencer;

`ifdef SEQ_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        start;
  logic        stop;
  logic [15:0] tempo;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  note_out;
  logic        gate;
  logic [2:0]  step_idx;
  logic        step_strobe;
  logic        busy;

  int tests = 0;
  int fails = 0;

  audio_note_sequencer #(.STEPS(8), .TEMPO_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
    .tempo(tempo), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note_out(note_out), .gate(gate), .step_idx(step_idx),
    .step_strobe(step_strobe), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic       ena, start, stop;
    logic [2:0] idx;
    logic [6:0] note;
    logic       gate, gate_gap, strobe, busy;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic e, logic s, logic p, logic [2:0] i,
                              logic [6:0] n, logic g, logic gg, logic st,
                              logic b);
    vec_t v;
    v.ena = e; v.start = s; v.stop = p; v.idx = i; v.note = n;
    v.gate = g; v.gate_gap = gg; v.strobe = st; v.busy = b;
    return v;
  endfunction

  task automatic expect_outs(input string tag, input logic [2:0] e_idx,
                             input logic [6:0] e_note, input logic e_gate,
                             input logic e_strobe, input logic e_busy);
    tests++;
    if (step_idx !== e_idx) begin
      fails++;
      $display("FAIL %s step_idx: got %0d want %0d", tag, step_idx, e_idx);
    end
    tests++;
    if (note_out !== e_note) begin
      fails++;
      $display("FAIL %s note_out: got 0x%02h want 0x%02h", tag, note_out, e_note);
    end
    tests++;
    if (gate !== e_gate) begin
      fails++;
      $display("FAIL %s gate: got %b want %b", tag, gate, e_gate);
    end
    tests++;
    if (step_strobe !== e_strobe) begin
      fails++;
      $display("FAIL %s step_strobe: got %b want %b", tag, step_strobe, e_strobe);
    end
    tests++;
    if (busy !== e_busy) begin
      fails++;
      $display("FAIL %s busy: got %b want %b", tag, busy, e_busy);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic play_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic play_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  initial begin
    logic [2:0] ei;
    logic       eg;

    // tempo = 0 -> 2-cycle steps; pattern 0..7 = 0x10..0x17
    vecs[0]  = mk(1'b1,1'b0,1'b0, 3'd0,7'h00, 1'b0,1'b0, 1'b0,1'b0);
    vecs[1]  = mk(1'b1,1'b0,1'b1, 3'd0,7'h00, 1'b0,1'b0, 1'b0,1'b0);
    vecs[2]  = mk(1'b1,1'b1,1'b0, 3'd0,7'h10, 1'b1,1'b1, 1'b1,1'b1);
    vecs[3]  = mk(1'b1,1'b0,1'b0, 3'd0,7'h10, 1'b1,1'b0, 1'b0,1'b1);
    vecs[4]  = mk(1'b1,1'b0,1'b0, 3'd1,7'h11, 1'b1,1'b1, 1'b1,1'b1);
    vecs[5]  = mk(1'b0,1'b1,1'b0, 3'd1,7'h11, 1'b1,1'b1, 1'b1,1'b1);
    vecs[6]  = mk(1'b0,1'b0,1'b1, 3'd1,7'h11, 1'b1,1'b1, 1'b1,1'b1);
    vecs[7]  = mk(1'b1,1'b0,1'b0, 3'd1,7'h11, 1'b1,1'b0, 1'b0,1'b1);
    vecs[8]  = mk(1'b1,1'b1,1'b1, 3'd0,7'h00, 1'b0,1'b0, 1'b0,1'b0);
    vecs[9]  = mk(1'b1,1'b1,1'b0, 3'd0,7'h10, 1'b1,1'b1, 1'b1,1'b1);
    vecs[10] = mk(1'b1,1'b0,1'b0, 3'd0,7'h10, 1'b1,1'b0, 1'b0,1'b1);
    vecs[11] = mk(1'b1,1'b0,1'b0, 3'd1,7'h11, 1'b1,1'b1, 1'b1,1'b1);
    vecs[12] = mk(1'b1,1'b1,1'b0, 3'd0,7'h10, 1'b1,1'b1, 1'b1,1'b1);
    vecs[13] = mk(1'b1,1'b0,1'b0, 3'd0,7'h10, 1'b1,1'b0, 1'b0,1'b1);
    vecs[14] = mk(1'b1,1'b0,1'b1, 3'd0,7'h00, 1'b0,1'b0, 1'b0,1'b0);

    rst_n = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; tempo = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #1 rst_n = 1'b0;
    #2 expect_outs("reset", 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    expect_outs("idle_after_reset", 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));

    // control table
    tempo = 16'd0;
    for (int i = 0; i < 15; i++) begin
      ena = vecs[i].ena; start = vecs[i].start; stop = vecs[i].stop;
      tick();
      expect_outs($sformatf("vec%0d", i), vecs[i].idx, vecs[i].note,
                  GAP ? vecs[i].gate_gap : vecs[i].gate,
                  vecs[i].strobe, vecs[i].busy);
    end
    ena = 1'b1; start = 1'b0; stop = 1'b0;

    // full pattern at tempo 3, including the wrap at cycle 33
    tempo = 16'd3;
    play_start();
    for (int c = 1; c <= 36; c++) begin
      if (c > 1) tick();
      ei = 3'(((c - 1) / 4) % 8);
      eg = !(GAP && ((c - 1) % 4 == 3));
      expect_outs($sformatf("play_c%0d", c), ei, 7'(7'h10 + ei), eg,
                  ((c - 1) % 4 == 0), 1'b1);
    end
    play_stop();
    expect_outs("play_stop", 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);

    // rest step
    tempo = 16'd2;
    wr(3'd2, 8'h85);
    play_start();
    repeat (6) tick();
    expect_outs("rest_c7", 3'd2, 7'h05, 1'b0, 1'b1, 1'b1);
    tick();
    expect_outs("rest_c8", 3'd2, 7'h05, 1'b0, 1'b0, 1'b1);
    tick();
    expect_outs("rest_c9", 3'd2, 7'h05, 1'b0, 1'b0, 1'b1);
    tick();
    expect_outs("rest_c10", 3'd3, 7'h13, 1'b1, 1'b1, 1'b1);
    play_stop();

    // restart at step 5, then start+stop together
    tempo = 16'd3;
    play_start();
    repeat (21) tick();
    expect_outs("ctl_step5", 3'd5, 7'h15, 1'b1, 1'b0, 1'b1);
    play_start();
    expect_outs("ctl_restart", 3'd0, 7'h10, 1'b1, 1'b1, 1'b1);
    tick();
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    expect_outs("ctl_both", 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);

    // ena freeze in the middle of step 3
    play_start();
    repeat (13) tick();
    expect_outs("frz_pre", 3'd3, 7'h13, 1'b1, 1'b0, 1'b1);
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      expect_outs($sformatf("frz_hold%0d", k), 3'd3, 7'h13, 1'b1, 1'b0, 1'b1);
    end
    ena = 1'b1;
    tick();
    expect_outs("frz_res1", 3'd3, 7'h13, 1'b1, 1'b0, 1'b1);
    tick();
    expect_outs("frz_res2", 3'd3, 7'h13, !GAP, 1'b0, 1'b1);
    tick();
    expect_outs("frz_res3", 3'd4, 7'h14, 1'b1, 1'b1, 1'b1);
    play_stop();

    // async reset in the middle of step 4
    play_start();
    repeat (17) tick();
    expect_outs("rst_pre", 3'd4, 7'h14, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1 expect_outs("rst_async", 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    expect_outs("rst_stay_idle", 3'd0, 7'h00, 1'b0, 1'b0, 1'b0);
    tempo = 16'd0;
    play_start();
    expect_outs("rst_pat0", 3'd0, 7'h00, 1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    expect_outs("rst_pat2", 3'd2, 7'h00, 1'b1, 1'b1, 1'b1);
    play_stop();

    // gate articulation with all notes 0x20
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h20);
    tempo = 16'd3;
    play_start();
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      ei = 3'((c - 1) / 4);
      eg = !(GAP && ((c - 1) % 4 == 3));
      expect_outs($sformatf("gap_c%0d", c), ei, 7'h20, eg,
                  ((c - 1) % 4 == 0), 1'b1);
    end
    play_stop();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
